// File: rtl/uart_cmd_ctrl.sv
// uart_cmd_ctrl: parses UART write/read register frames and returns read data to the UART transmitter
module uart_cmd_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int RD_TIMEOUT = 15
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] RX_P_DATA,
  input  logic                  RX_D_VLD,
  output logic [ADDR_WIDTH-1:0] RF_ADDR,
  output logic                  RF_WR_EN,
  output logic [DATA_WIDTH-1:0] RF_WR_DATA,
  output logic                  RF_RD_EN,
  input  logic [DATA_WIDTH-1:0] RF_RD_DATA,
  input  logic                  RF_RD_VLD,
  output logic [DATA_WIDTH-1:0] TX_P_DATA,
  output logic                  TX_D_VLD,
  input  logic                  TX_BUSY,
  output logic                  CMD_ERR
);
  localparam int CW = $clog2(RD_TIMEOUT + 1);
  localparam logic [DATA_WIDTH-1:0] OP_WR = DATA_WIDTH'(8'hAA);
  localparam logic [DATA_WIDTH-1:0] OP_RD = DATA_WIDTH'(8'hBB);
  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] WR_ADDR = 3'd1;
  localparam logic [2:0] WR_DATA = 3'd2;
  localparam logic [2:0] RD_ADDR = 3'd3;
  localparam logic [2:0] RD_REQ  = 3'd4;
  localparam logic [2:0] RD_WAIT = 3'd5;
  localparam logic [2:0] TX_SEND = 3'd6;
  logic [2:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdat_q, wdat_d, tdat_q, tdat_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  wr_en_q, wr_en_d, rd_en_q, rd_en_d, tx_vld_q, tx_vld_d, err_q, err_d;
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdat_d   = wdat_q;
    tdat_d   = tdat_q;
    cnt_d    = cnt_q;
    wr_en_d  = 1'b0;
    rd_en_d  = 1'b0;
    tx_vld_d = 1'b0;
    // bytes arriving while a read is in flight are dropped and flagged
    err_d    = RX_D_VLD && (state_q == RD_REQ || state_q == RD_WAIT || state_q == TX_SEND);
    case (state_q)
      IDLE: if (RX_D_VLD) begin
        state_d = (RX_P_DATA == OP_WR) ? WR_ADDR : (RX_P_DATA == OP_RD) ? RD_ADDR : IDLE;
        err_d   = (RX_P_DATA != OP_WR) && (RX_P_DATA != OP_RD);
      end
      WR_ADDR: if (RX_D_VLD) begin
        addr_d  = RX_P_DATA[ADDR_WIDTH-1:0];
        state_d = WR_DATA;
      end
      WR_DATA: if (RX_D_VLD) begin
        wdat_d  = RX_P_DATA;
        wr_en_d = 1'b1;
        state_d = IDLE;
      end
      RD_ADDR: if (RX_D_VLD) begin
        addr_d  = RX_P_DATA[ADDR_WIDTH-1:0];
        state_d = RD_REQ;
      end
      RD_REQ: begin
        rd_en_d = 1'b1;
        cnt_d   = '0;
        state_d = RD_WAIT;
      end
      RD_WAIT: if (RF_RD_VLD) begin
        tdat_d  = RF_RD_DATA;
        state_d = TX_SEND;
      end else if (cnt_q == CW'(RD_TIMEOUT - 1)) begin
        err_d   = 1'b1;
        state_d = IDLE;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
      TX_SEND: if (!TX_BUSY) begin
        tx_vld_d = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      wdat_q   <= '0;
      tdat_q   <= '0;
      cnt_q    <= '0;
      wr_en_q  <= 1'b0;
      rd_en_q  <= 1'b0;
      tx_vld_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdat_q   <= wdat_d;
      tdat_q   <= tdat_d;
      cnt_q    <= cnt_d;
      wr_en_q  <= wr_en_d;
      rd_en_q  <= rd_en_d;
      tx_vld_q <= tx_vld_d;
      err_q    <= err_d;
    end
  end
  assign RF_ADDR    = addr_q;
  assign RF_WR_EN   = wr_en_q;
  assign RF_WR_DATA = wdat_q;
  assign RF_RD_EN   = rd_en_q;
  assign TX_P_DATA  = tdat_q;
  assign TX_D_VLD   = tx_vld_q;
  assign CMD_ERR    = err_q;
endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// tb_uart_cmd_ctrl: frame vectors and corner sequences against a strobe scoreboard
module tb_uart_cmd_ctrl;
  logic       CLK = 1'b0;
  logic       RST, RX_D_VLD, RF_WR_EN, RF_RD_EN, RF_RD_VLD, TX_D_VLD, TX_BUSY, CMD_ERR;
  logic [7:0] RX_P_DATA, RF_WR_DATA, RF_RD_DATA, TX_P_DATA;
  logic [3:0] RF_ADDR;
  uart_cmd_ctrl dut (
    .CLK(CLK), .RST(RST), .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
    .RF_ADDR(RF_ADDR), .RF_WR_EN(RF_WR_EN), .RF_WR_DATA(RF_WR_DATA), .RF_RD_EN(RF_RD_EN),
    .RF_RD_DATA(RF_RD_DATA), .RF_RD_VLD(RF_RD_VLD), .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD),
    .TX_BUSY(TX_BUSY), .CMD_ERR(CMD_ERR)
  );
  always #5 CLK = ~CLK;
  typedef struct packed { logic [1:0] k; logic [3:0] a; logic [7:0] d; } ev_t;
  typedef struct { int nb; logic [7:0] b0; logic [7:0] b1; logic [7:0] b2; logic [7:0] rv; } vec_t;
  ev_t  q[$];
  vec_t vt[7];
  int   nchk = 0, nerr = 0, cyc = 0, t_rd = 0, t_err = 0;
  logic rf_on = 1'b1;
  logic [7:0] rf_val = 8'h00;
  // register file responds one cycle after each read strobe
  always @(posedge CLK) begin
    cyc <= cyc + 1;
    RF_RD_VLD  <= RF_RD_EN && rf_on;
    RF_RD_DATA <= rf_val;
  end
  task automatic check(input string n, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%h required=%h", n, got, exp);
    end
  endtask
  task automatic chk_ev(input logic [1:0] k, input logic [3:0] a, input logic [7:0] d);
    ev_t e;
    nchk++;
    if (q.size() == 0) begin
      nerr++;
      $display("FAIL unexpected_strobe got kind=%0d addr=%h data=%h required none", k, a, d);
    end else begin
      e = q.pop_front();
      if (e !== {k, a, d}) begin
        nerr++;
        $display("FAIL strobe got kind=%0d addr=%h data=%h required kind=%0d addr=%h data=%h",
                 k, a, d, e.k, e.a, e.d);
      end
    end
  endtask
  always @(negedge CLK) if (RST) begin
    if (CMD_ERR) begin t_err = cyc; chk_ev(2'd0, 4'd0, 8'd0); end
    if (RF_WR_EN) chk_ev(2'd1, RF_ADDR, RF_WR_DATA);
    if (RF_RD_EN) begin t_rd = cyc; chk_ev(2'd2, RF_ADDR, 8'd0); end
    if (TX_D_VLD) chk_ev(2'd3, 4'd0, TX_P_DATA);
  end
  task automatic expect_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2, input logic [7:0] rv);
    if (b0 == 8'hAA) q.push_back({2'd1, b1[3:0], b2});
    else if (b0 == 8'hBB) begin
      q.push_back({2'd2, b1[3:0], 8'd0});
      q.push_back({2'd3, 4'd0, rv});
    end else q.push_back({2'd0, 4'd0, 8'd0});
  endtask
  task automatic send(input int n, input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    logic [7:0] b[3];
    b = '{b0, b1, b2};
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      RX_P_DATA = b[i];
      RX_D_VLD  = 1'b1;
    end
    @(negedge CLK);
    RX_D_VLD = 1'b0;
  endtask
  task automatic wait_idle(input string n);
    int c = 0;
    while (q.size() != 0 && c < 60) begin
      @(negedge CLK);
      c++;
    end
    check(n, q.size(), 0);
    q.delete();
    repeat (3) @(negedge CLK);
  endtask
  initial begin
    RST = 1'b0; RX_D_VLD = 1'b0; RX_P_DATA = 8'h00; TX_BUSY = 1'b0;
    vt[0] = '{3, 8'hAA, 8'h05, 8'h3C, 8'h00};
    vt[1] = '{2, 8'hBB, 8'h13, 8'h00, 8'h7E};
    vt[2] = '{1, 8'h42, 8'h00, 8'h00, 8'h00};
    vt[3] = '{3, 8'hAA, 8'h01, 8'h11, 8'h00};
    vt[4] = '{3, 8'hAA, 8'hFF, 8'h00, 8'h00};
    vt[5] = '{2, 8'hBB, 8'hA0, 8'h00, 8'h81};
    vt[6] = '{3, 8'hAA, 8'h3A, 8'hFF, 8'h00};
    repeat (3) @(negedge CLK);
    check("reset_outputs", {RF_ADDR, RF_WR_EN, RF_WR_DATA, RF_RD_EN, TX_P_DATA, TX_D_VLD, CMD_ERR}, 0);
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    for (int i = 0; i < 7; i++) begin
      rf_val = vt[i].rv;
      expect_frame(vt[i].b0, vt[i].b1, vt[i].b2, vt[i].rv);
      send(vt[i].nb, vt[i].b0, vt[i].b1, vt[i].b2);
      wait_idle($sformatf("vector%0d_drain", i));
    end
    check("tx_data_held", TX_P_DATA, 8'h81);
    check("rf_addr_held", RF_ADDR, 4'hA);
    check("rf_wr_data_held", RF_WR_DATA, 8'hFF);
    TX_BUSY = 1'b1;
    rf_val  = 8'h5A;
    expect_frame(8'hBB, 8'h07, 8'h00, 8'h5A);
    send(2, 8'hBB, 8'h07, 8'h00);
    repeat (20) @(negedge CLK);
    check("busy_tx_withheld", q.size(), 1);
    TX_BUSY = 1'b0;
    wait_idle("busy_release_drain");
    rf_on = 1'b0;
    expect_frame(8'hBB, 8'h04, 8'h00, 8'h00);
    q.pop_back();
    q.push_back({2'd0, 4'd0, 8'd0});
    send(2, 8'hBB, 8'h04, 8'h00);
    wait_idle("timeout_drain");
    check("timeout_cycles", t_err - t_rd, 15);
    rf_on = 1'b1;
    expect_frame(8'hAA, 8'h0C, 8'hC3, 8'h00);
    send(3, 8'hAA, 8'h0C, 8'hC3);
    wait_idle("after_timeout_write");
    rf_val = 8'h33;
    q.push_back({2'd0, 4'd0, 8'd0});
    expect_frame(8'hBB, 8'h02, 8'h00, 8'h33);
    send(3, 8'hBB, 8'h02, 8'h55);
    wait_idle("rx_during_read_drain");
    send(2, 8'hAA, 8'h05, 8'h00);
    @(negedge CLK);
    RST = 1'b0;
    #1;
    check("midframe_reset_outputs", {RF_ADDR, RF_WR_EN, RF_WR_DATA, RF_RD_EN, TX_P_DATA, TX_D_VLD, CMD_ERR}, 0);
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    expect_frame(8'hAA, 8'h09, 8'h22, 8'h00);
    send(3, 8'hAA, 8'h09, 8'h22);
    wait_idle("after_reset_write");
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nerr);
    $finish;
  end
endmodule
